// File: rtl/seq_frame_tx.sv
// seq_frame_tx: serial frame transmitter (preamble, MSB-first payload, optional parity, idle gap).
// Define SEQ_FRAME_TX_PARITY_EN to append an even-parity bit after the payload.
module seq_frame_tx #(
    parameter int         WIDTH    = 8,
    parameter logic [3:0] PREAMBLE = 4'b1010,
    parameter int         GAP_LEN  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             done
);
    localparam int CW = ($clog2(WIDTH) + 1 > 4) ? $clog2(WIDTH) + 1 : 4;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        DATA = 3'd2,
        PAR  = 3'd3,
        GAP  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic             dout_q, dout_d;
    logic             dv_q, dv_d;
    logic             done_q, done_d;
    logic [3:0]       pre_sh;
`ifdef SEQ_FRAME_TX_PARITY_EN
    logic             par_q, par_d;
`endif

    // cnt_q counts bits already emitted in the current state; each branch emits the next one
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        dout_d  = 1'b0;
        dv_d    = 1'b0;
        done_d  = 1'b0;
        pre_sh  = PREAMBLE << cnt_q;
`ifdef SEQ_FRAME_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    state_d = PRE;
                    cnt_d   = CW'(1);
                    sh_d    = data_in;
`ifdef SEQ_FRAME_TX_PARITY_EN
                    par_d   = ^data_in;
`endif
                    dout_d  = PREAMBLE[3];
                    dv_d    = 1'b1;
                end
            end
            PRE: begin
                dv_d = 1'b1;
                if (cnt_q == CW'(4)) begin
                    state_d = DATA;
                    cnt_d   = CW'(1);
                    dout_d  = sh_q[WIDTH-1];
                    sh_d    = sh_q << 1;
                end else begin
                    cnt_d  = cnt_q + CW'(1);
                    dout_d = pre_sh[3];
                end
            end
            DATA: begin
                if (cnt_q == CW'(WIDTH)) begin
                    cnt_d = CW'(1);
`ifdef SEQ_FRAME_TX_PARITY_EN
                    state_d = PAR;
                    dout_d  = par_q;
                    dv_d    = 1'b1;
`else
                    state_d = GAP;
`endif
                end else begin
                    cnt_d  = cnt_q + CW'(1);
                    dout_d = sh_q[WIDTH-1];
                    sh_d   = sh_q << 1;
                    dv_d   = 1'b1;
                end
            end
`ifdef SEQ_FRAME_TX_PARITY_EN
            PAR: begin
                state_d = GAP;
                cnt_d   = CW'(1);
            end
`endif
            GAP: begin
                if (cnt_q == CW'(GAP_LEN)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            dout_q  <= 1'b0;
            dv_q    <= 1'b0;
            done_q  <= 1'b0;
`ifdef SEQ_FRAME_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            dout_q  <= dout_d;
            dv_q    <= dv_d;
            done_q  <= done_d;
`ifdef SEQ_FRAME_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign ready_out  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign dout       = dout_q;
    assign dout_valid = dv_q;
    assign done       = done_q;
endmodule

// File: tb/tb_seq_frame_tx.sv
// tb_seq_frame_tx: randomized self-checking bench for seq_frame_tx against a slot-level frame model.
module tb_seq_frame_tx;
    localparam int W = 8;
    localparam int G = 2;
`ifdef SEQ_FRAME_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int FL = 4 + W + P;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         valid_in = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         ready_out, dout, dout_valid, busy, done;
    int           checks = 0;
    int           fails = 0;

    seq_frame_tx #(.WIDTH(W), .PREAMBLE(4'b1010), .GAP_LEN(G)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in),
        .ready_out(ready_out), .dout(dout), .dout_valid(dout_valid),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Expected line bit for frame slot i: preamble, payload MSB first, then even parity
    function automatic logic exp_bit(input logic [W-1:0] d, input int i);
        logic [3:0] pre;
        pre = 4'b1010;
        if (i < 4) return pre[3-i];
        if (i < 4 + W) return d[W-1-(i-4)];
        return ^d;
    endfunction

    // {dout, dout_valid, busy, done, ready_out} in the cycle after edge k+i
    function automatic logic [4:0] exp_out(input logic [W-1:0] d, input int i);
        if (i < FL) return {exp_bit(d, i), 4'b1100};
        if (i < FL + G) return 5'b00100;
        return 5'b00011;
    endfunction

    task automatic tx_frame(input logic [W-1:0] d, input bit keep, input logic [W-1:0] nd,
                            input bit poke, input string name);
        logic [4:0] obs;
        int n;
        n = 0;
        while (ready_out !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (ready_out !== 1'b1) begin
            fails++;
            $display("FAIL %s ready wait: ready_out=%b required 1", name, ready_out);
        end
        data_in  = d;
        valid_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (keep) data_in = nd;
        else valid_in = 1'b0;
        for (int i = 0; i <= FL + G; i++) begin
            if (i > 0) @(negedge clk);
            obs = {dout, dout_valid, busy, done, ready_out};
            checks++;
            if (obs !== exp_out(d, i)) begin
                fails++;
                $display("FAIL %s d=%h slot %0d: got %b required %b", name, d, i, obs, exp_out(d, i));
            end
            if (poke && i == 6) begin
                valid_in = 1'b1;
                data_in  = 8'hAA;
            end
            if (poke && i == 7) valid_in = 1'b0;
        end
    endtask

    task automatic test_reset;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({dout, dout_valid, busy, done, ready_out} !== 5'b00001) begin
            fails++;
            $display("FAIL reset_async: got %b required 00001", {dout, dout_valid, busy, done, ready_out});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({dout, dout_valid, busy, done, ready_out} !== 5'b00001) begin
            fails++;
            $display("FAIL reset_release: got %b required 00001", {dout, dout_valid, busy, done, ready_out});
        end
    endtask

    task automatic test_single;
        tx_frame(8'hC5, 1'b0, '0, 1'b0, "single_c5");
    endtask

    task automatic test_parity;
        tx_frame(8'h01, 1'b0, '0, 1'b0, "parity_01");
        tx_frame(8'hFF, 1'b0, '0, 1'b0, "parity_ff");
    endtask

    task automatic test_busy_ignore;
        tx_frame(8'h5A, 1'b0, '0, 1'b1, "busy_ignore");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({dout, dout_valid, busy, done, ready_out} !== 5'b00001) begin
                fails++;
                $display("FAIL busy_ignore_idle cyc %0d: got %b required 00001", i,
                         {dout, dout_valid, busy, done, ready_out});
            end
        end
    endtask

    task automatic test_back_to_back;
        tx_frame(8'h3C, 1'b1, 8'h96, 1'b0, "b2b_first");
        tx_frame(8'h96, 1'b0, '0, 1'b0, "b2b_second");
    endtask

    task automatic test_random;
        logic [W-1:0] d, nd;
        bit keep;
        d = W'($urandom);
        for (int f = 0; f < 10; f++) begin
            keep = 1'($urandom_range(0, 1));
            nd = W'($urandom);
            tx_frame(d, keep, nd, 1'b0, "random");
            if (!keep) repeat ($urandom_range(0, 3)) @(negedge clk);
            d = nd;
        end
        valid_in = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mid_reset;
        data_in  = 8'hE7;
        valid_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid_in = 1'b0;
        repeat (6) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({dout, dout_valid, busy, done, ready_out} !== 5'b00001) begin
            fails++;
            $display("FAIL mid_reset_async: got %b required 00001", {dout, dout_valid, busy, done, ready_out});
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if ({dout, dout_valid, busy, done, ready_out} !== 5'b00001) begin
                fails++;
                $display("FAIL mid_reset_quiet cyc %0d: got %b required 00001", i,
                         {dout, dout_valid, busy, done, ready_out});
            end
        end
        tx_frame(8'h0F, 1'b0, '0, 1'b0, "after_reset_0f");
    endtask

    initial begin
        test_reset();
        test_single();
        test_parity();
        test_busy_ignore();
        test_back_to_back();
        test_random();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
